// File: rtl/cpu_alu_seq.sv
// Sequenced 8008 ALU: reads A (and B) from the register bank, computes ALU/rotate,
// updates C/Z/S/P and writes the result back to A over a 6-state FSM.
module cpu_alu_seq #(
    parameter logic [2:0] ACC_ADDR        = 3'd0,
    parameter bit         RESERVED_AS_NOP = 1'b1
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CMD_VALID_I,
    input  logic [3:0] CMD_OP_I,
    input  logic [2:0] CMD_SRC_I,
    input  logic       CMD_IMMEN_I,
    input  logic [7:0] CMD_IMM_I,
    output logic       BUSY_O,
    output logic       DONE_O,
    output logic       REG_CS_O,
    output logic       REG_RD_O,
    output logic       REG_WR_O,
    output logic [2:0] REG_ADDR_O,
    input  logic [7:0] REG_DAT_I,
    output logic [7:0] REG_DAT_O,
    output logic       FLAG_C_O,
    output logic       FLAG_Z_O,
    output logic       FLAG_S_O,
    output logic       FLAG_P_O
);

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [3:0] r_op;
    logic [2:0] r_src;
    logic       r_immen;
    logic [7:0] r_imm;
    logic [7:0] r_tmp_a, r_tmp_b, r_result;
    logic       r_flag_c, r_flag_z, r_flag_s, r_flag_p;

    logic       w_rsv, w_nop_cmd, w_is_rot;
    logic [8:0] w_wide;
    logic [7:0] w_res;
    logic       w_c, w_z, w_s, w_p;

    // Reserved opcodes currently finish as NOP either way; the trap variant hooks in here.
    assign w_rsv     = (CMD_OP_I[3:2] == 2'b11);
    assign w_nop_cmd = RESERVED_AS_NOP ? w_rsv : w_rsv;
    assign w_is_rot  = (r_op[3:2] == 2'b10);

    always_comb begin
        w_wide = 9'd0;
        w_res  = 8'd0;
        w_c    = r_flag_c;
        if (!r_op[3]) begin
            case (r_op[2:0])
                3'd0:    w_wide = {1'b0, r_tmp_a} + {1'b0, r_tmp_b};
                3'd1:    w_wide = {1'b0, r_tmp_a} + {1'b0, r_tmp_b} + {8'd0, r_flag_c};
                3'd3:    w_wide = {1'b0, r_tmp_a} - {1'b0, r_tmp_b} - {8'd0, r_flag_c};
                3'd4:    w_wide = {1'b0, r_tmp_a & r_tmp_b};
                3'd5:    w_wide = {1'b0, r_tmp_a ^ r_tmp_b};
                3'd6:    w_wide = {1'b0, r_tmp_a | r_tmp_b};
                default: w_wide = {1'b0, r_tmp_a} - {1'b0, r_tmp_b};
            endcase
            // Logic ops produce bit8=0, which clears C as required.
            w_res = w_wide[7:0];
            w_c   = w_wide[8];
        end else begin
            case (r_op[1:0])
                2'd0: begin w_res = {r_tmp_a[6:0], r_tmp_a[7]}; w_c = r_tmp_a[7]; end
                2'd1: begin w_res = {r_tmp_a[0], r_tmp_a[7:1]}; w_c = r_tmp_a[0]; end
                2'd2: begin w_res = {r_tmp_a[6:0], r_flag_c};   w_c = r_tmp_a[7]; end
                default: begin w_res = {r_flag_c, r_tmp_a[7:1]}; w_c = r_tmp_a[0]; end
            endcase
        end
        w_z = w_is_rot ? r_flag_z : (w_res == 8'd0);
        w_s = w_is_rot ? r_flag_s : w_res[7];
        w_p = w_is_rot ? r_flag_p : ~^w_res;
    end

    always_comb begin
        w_next     = r_state;
        REG_CS_O   = 1'b0;
        REG_RD_O   = 1'b0;
        REG_WR_O   = 1'b0;
        REG_ADDR_O = 3'd0;
        REG_DAT_O  = 8'd0;
        DONE_O     = 1'b0;
        BUSY_O     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (CMD_VALID_I) w_next = w_nop_cmd ? S_DONE : S_RDA;
            end
            S_RDA: begin
                REG_CS_O   = 1'b1;
                REG_RD_O   = 1'b1;
                REG_ADDR_O = ACC_ADDR;
                w_next     = (w_is_rot || r_immen) ? S_EXEC : S_RDB;
            end
            S_RDB: begin
                REG_CS_O   = 1'b1;
                REG_RD_O   = 1'b1;
                REG_ADDR_O = r_src;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_next = (r_op == 4'd7) ? S_DONE : S_WB;
            end
            S_WB: begin
                REG_CS_O   = 1'b1;
                REG_WR_O   = 1'b1;
                REG_ADDR_O = ACC_ADDR;
                REG_DAT_O  = r_result;
                w_next     = S_DONE;
            end
            S_DONE: begin
                DONE_O = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state  <= S_IDLE;
            r_op     <= 4'd0;
            r_src    <= 3'd0;
            r_immen  <= 1'b0;
            r_imm    <= 8'd0;
            r_tmp_a  <= 8'd0;
            r_tmp_b  <= 8'd0;
            r_result <= 8'd0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_s <= 1'b0;
            r_flag_p <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (CMD_VALID_I) begin
                        r_op    <= CMD_OP_I;
                        r_src   <= CMD_SRC_I;
                        r_immen <= CMD_IMMEN_I;
                        r_imm   <= CMD_IMM_I;
                    end
                end
                S_RDA: begin
                    r_tmp_a <= REG_DAT_I;
                    if (!w_is_rot && r_immen) r_tmp_b <= r_imm;
                end
                S_RDB: r_tmp_b <= REG_DAT_I;
                S_EXEC: begin
                    r_result <= w_res;
                    r_flag_c <= w_c;
                    r_flag_z <= w_z;
                    r_flag_s <= w_s;
                    r_flag_p <= w_p;
                end
                default: ;
            endcase
        end
    end

    assign FLAG_C_O = r_flag_c;
    assign FLAG_Z_O = r_flag_z;
    assign FLAG_S_O = r_flag_s;
    assign FLAG_P_O = r_flag_p;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed bench for cpu_alu_seq: behavioural register bank, vector table with
// hand-computed results/latencies, plus handshake and mid-op reset sequences.
module tb_cpu_alu_seq;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic       CMD_VALID_I;
    logic [3:0] CMD_OP_I;
    logic [2:0] CMD_SRC_I;
    logic       CMD_IMMEN_I;
    logic [7:0] CMD_IMM_I;
    logic       BUSY_O, DONE_O, REG_CS_O, REG_RD_O, REG_WR_O;
    logic [2:0] REG_ADDR_O;
    logic [7:0] REG_DAT_I, REG_DAT_O;
    logic       FLAG_C_O, FLAG_Z_O, FLAG_S_O, FLAG_P_O;

    logic [7:0] bank [8];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK_I = ~CLK_I;

    assign REG_DAT_I = bank[REG_ADDR_O];

    cpu_alu_seq dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .CMD_VALID_I(CMD_VALID_I), .CMD_OP_I(CMD_OP_I), .CMD_SRC_I(CMD_SRC_I),
        .CMD_IMMEN_I(CMD_IMMEN_I), .CMD_IMM_I(CMD_IMM_I),
        .BUSY_O(BUSY_O), .DONE_O(DONE_O),
        .REG_CS_O(REG_CS_O), .REG_RD_O(REG_RD_O), .REG_WR_O(REG_WR_O),
        .REG_ADDR_O(REG_ADDR_O), .REG_DAT_I(REG_DAT_I), .REG_DAT_O(REG_DAT_O),
        .FLAG_C_O(FLAG_C_O), .FLAG_Z_O(FLAG_Z_O), .FLAG_S_O(FLAG_S_O), .FLAG_P_O(FLAG_P_O)
    );

    typedef struct {
        logic       pa_en;
        logic [7:0] pa;
        logic       pb_en;
        logic [7:0] pb;
        logic [3:0] op;
        logic [2:0] src;
        logic       immen;
        logic [7:0] imm;
        logic [7:0] ea;
        logic [3:0] ef;   // {C,Z,S,P}
        int         lat;
        int         nwr;
        int         nrd;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic pa_en, input logic [7:0] pa, input logic pb_en,
                                input logic [7:0] pb, input logic [3:0] op, input logic [2:0] src,
                                input logic immen, input logic [7:0] imm, input logic [7:0] ea,
                                input logic [3:0] ef, input int lat, input int nwr, input int nrd);
        vec_t v;
        v.pa_en = pa_en; v.pa = pa; v.pb_en = pb_en; v.pb = pb;
        v.op = op; v.src = src; v.immen = immen; v.imm = imm;
        v.ea = ea; v.ef = ef; v.lat = lat; v.nwr = nwr; v.nrd = nrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bank model: a WR cycle commits at the mid-cycle sample point, discarded under reset.
    task automatic tick();
        @(negedge CLK_I);
        if (REG_CS_O && REG_WR_O && !RST_I) bank[REG_ADDR_O] = REG_DAT_O;
    endtask

    function automatic logic [3:0] flags();
        return {FLAG_C_O, FLAG_Z_O, FLAG_S_O, FLAG_P_O};
    endfunction

    task automatic run_cmd(input vec_t v, input int idx);
        int lat, nwr, nrd, ncs;
        logic [2:0] wa;
        lat = 0; nwr = 0; nrd = 0; ncs = 0; wa = 3'd7;
        tick();
        chk($sformatf("v%0d_idle_busy", idx), {31'd0, BUSY_O}, 32'd0);
        if (v.pa_en) bank[0] = v.pa;
        if (v.pb_en) bank[v.src] = v.pb;
        CMD_OP_I = v.op; CMD_SRC_I = v.src; CMD_IMMEN_I = v.immen; CMD_IMM_I = v.imm;
        CMD_VALID_I = 1'b1;
        @(posedge CLK_I);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) CMD_VALID_I = 1'b0;
            if (REG_CS_O) ncs++;
            if (REG_CS_O && REG_RD_O) nrd++;
            if (REG_CS_O && REG_WR_O) begin nwr++; wa = REG_ADDR_O; end
            if (DONE_O) begin lat = k; break; end
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_wr_cnt", idx), nwr, v.nwr);
        chk($sformatf("v%0d_rd_cnt", idx), nrd, v.nrd);
        chk($sformatf("v%0d_cs_cnt", idx), ncs, v.nrd + v.nwr);
        if (v.nwr > 0) chk($sformatf("v%0d_wr_addr", idx), {29'd0, wa}, 32'd0);
        chk($sformatf("v%0d_acc", idx), {24'd0, bank[0]}, {24'd0, v.ea});
        chk($sformatf("v%0d_flags", idx), {28'd0, flags()}, {28'd0, v.ef});
    endtask

    initial begin
        int d1, d2, idle_k, rda2, nwr;
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;
        RST_I = 1'b1; CMD_VALID_I = 1'b0; CMD_OP_I = 4'd0; CMD_SRC_I = 3'd0;
        CMD_IMMEN_I = 1'b0; CMD_IMM_I = 8'd0;

        //        paen pa    pben pb    op     src  imm imm    ea     CZSP     lat wr rd
        vt[0]  = mk(1, 8'h3C, 1, 8'hC8, 4'd0,  3'd2, 0, 8'h00, 8'h04, 4'b1000, 5, 1, 2);
        vt[1]  = mk(1, 8'h81, 0, 8'h00, 4'd6,  3'd0, 1, 8'h01, 8'h81, 4'b0011, 4, 1, 1);
        vt[2]  = mk(1, 8'h10, 0, 8'h00, 4'd2,  3'd0, 1, 8'h20, 8'hF0, 4'b1011, 4, 1, 1);
        vt[3]  = mk(1, 8'h05, 1, 8'h05, 4'd3,  3'd1, 0, 8'h00, 8'hFF, 4'b1011, 5, 1, 2);
        vt[4]  = mk(1, 8'h10, 0, 8'h00, 4'd1,  3'd0, 1, 8'h0F, 8'h20, 4'b0000, 4, 1, 1);
        vt[5]  = mk(1, 8'hF0, 1, 8'h3C, 4'd5,  3'd4, 0, 8'h00, 8'hCC, 4'b0011, 5, 1, 2);
        vt[6]  = mk(1, 8'hF0, 0, 8'h00, 4'd4,  3'd0, 1, 8'h0F, 8'h00, 4'b0101, 4, 1, 1);
        vt[7]  = mk(1, 8'h55, 1, 8'h55, 4'd7,  3'd3, 0, 8'h00, 8'h55, 4'b0101, 4, 0, 2);
        vt[8]  = mk(1, 8'h10, 0, 8'h00, 4'd7,  3'd0, 1, 8'h20, 8'h10, 4'b1011, 3, 0, 1);
        vt[9]  = mk(1, 8'h81, 0, 8'h00, 4'd0,  3'd0, 0, 8'h00, 8'h02, 4'b1000, 5, 1, 2);
        vt[10] = mk(1, 8'h02, 0, 8'h00, 4'd14, 3'd5, 0, 8'h00, 8'h02, 4'b1000, 1, 0, 0);
        vt[11] = mk(1, 8'h81, 0, 8'h00, 4'd10, 3'd0, 0, 8'h00, 8'h03, 4'b1000, 4, 1, 1);
        vt[12] = mk(0, 8'h00, 0, 8'h00, 4'd9,  3'd0, 0, 8'h00, 8'h81, 4'b1000, 4, 1, 1);
        vt[13] = mk(0, 8'h00, 0, 8'h00, 4'd11, 3'd0, 0, 8'h00, 8'hC0, 4'b1000, 4, 1, 1);
        vt[14] = mk(0, 8'h00, 0, 8'h00, 4'd8,  3'd0, 0, 8'h00, 8'h81, 4'b1000, 4, 1, 1);
        vt[15] = mk(1, 8'h02, 0, 8'h00, 4'd9,  3'd0, 0, 8'h00, 8'h01, 4'b0000, 4, 1, 1);
        vt[16] = mk(1, 8'h80, 0, 8'h00, 4'd10, 3'd0, 0, 8'h00, 8'h00, 4'b1000, 4, 1, 1);
        vt[17] = mk(1, 8'h00, 0, 8'h00, 4'd3,  3'd0, 1, 8'h00, 8'hFF, 4'b1011, 4, 1, 1);

        // Reset state, sampled in the cycle after the first reset edge
        @(posedge CLK_I);
        tick();
        chk("rst_busy", {31'd0, BUSY_O}, 32'd0);
        chk("rst_done", {31'd0, DONE_O}, 32'd0);
        chk("rst_ctl", {29'd0, REG_CS_O, REG_RD_O, REG_WR_O}, 32'd0);
        chk("rst_addr_dat", {21'd0, REG_ADDR_O, REG_DAT_O}, 32'd0);
        chk("rst_flags", {28'd0, flags()}, 32'd0);
        tick();
        RST_I = 1'b0;

        for (int i = 0; i < 18; i++) run_cmd(vt[i], i);

        // Valid held high across two ADD-immediate commands
        tick();
        bank[0] = 8'h01;
        CMD_OP_I = 4'd0; CMD_SRC_I = 3'd0; CMD_IMMEN_I = 1'b1; CMD_IMM_I = 8'h01;
        CMD_VALID_I = 1'b1;
        d1 = 0; d2 = 0; idle_k = 0; rda2 = 0;
        @(posedge CLK_I);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (!BUSY_O && idle_k == 0) idle_k = k;
            if (d1 != 0 && k > d1 && REG_RD_O && rda2 == 0) rda2 = k;
            if (d1 != 0 && k == d1 + 2) CMD_VALID_I = 1'b0;
            if (DONE_O) begin
                if (d1 == 0) d1 = k;
                else begin d2 = k; break; end
            end
        end
        CMD_VALID_I = 1'b0;
        chk("hs_done1", d1, 4);
        chk("hs_idle", idle_k, 5);
        chk("hs_rda2", rda2, 6);
        chk("hs_done2", d2, 9);
        tick();
        tick();
        chk("hs_no_third", {31'd0, BUSY_O}, 32'd0);
        chk("hs_acc", {24'd0, bank[0]}, 32'h03);
        chk("hs_flags", {28'd0, flags()}, 32'b0001);

        // Reset during RDB of an ADD register
        bank[0] = 8'h11; bank[2] = 8'h22;
        CMD_OP_I = 4'd0; CMD_SRC_I = 3'd2; CMD_IMMEN_I = 1'b0; CMD_IMM_I = 8'h00;
        CMD_VALID_I = 1'b1;
        @(posedge CLK_I);
        tick();
        CMD_VALID_I = 1'b0;
        tick();
        chk("mr_in_rdb", {28'd0, REG_RD_O, REG_ADDR_O}, {28'd0, 1'b1, 3'd2});
        RST_I = 1'b1;
        nwr = 0;
        tick();
        chk("mr_busy", {31'd0, BUSY_O}, 32'd0);
        chk("mr_flags", {28'd0, flags()}, 32'd0);
        if (REG_WR_O) nwr++;
        RST_I = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (REG_WR_O) nwr++;
        end
        chk("mr_no_wr", nwr, 0);
        chk("mr_acc", {24'd0, bank[0]}, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
- Sequenced ALU for the Intel8008 CPU core. Sits directly downstream of the 8-entry register bank and drives that bank's control/address/data ports.
- On each accepted command it:
  - reads accumulator A (bank entry 0), and optionally a source register or an immediate;
  - computes the 8008 ALU/rotate result;
  - updates the C/Z/S/P flags;
  - writes the result back to A.
- Commands come from the instruction decoder via a valid/busy/done handshake.

Parameters:
- ACC_ADDR, 3'd0, bank address of accumulator A.
- RESERVED_AS_NOP, 1, 1 = opcodes 12..15 complete as NOP; 0 = same (reserved for future trap, no behaviour difference now).

Ports:
- CLK_I  input  1  clock; all state changes on rising edge.
- RST_I  input  1  reset; synchronous, active-high.
- CMD_VALID_I  input  1  command request, sampled only in IDLE.
- CMD_OP_I  input  4  0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 ANA, 5 XRA, 6 ORA, 7 CMP, 8 RLC, 9 RRC, 10 RAL, 11 RAR, 12-15 NOP.
- CMD_SRC_I  input  3  source register address for ops 0-7 when CMD_IMMEN_I=0.
- CMD_IMMEN_I  input  1  1 = use CMD_IMM_I as operand B.
- CMD_IMM_I  input  8  immediate operand.
- BUSY_O  output  1  high in every state except IDLE.
- DONE_O  output  1  one-cycle pulse in DONE state.
- REG_CS_O  output  1  bank chip select.
- REG_RD_O  output  1  bank read enable (bank read data is combinational).
- REG_WR_O  output  1  bank write enable (bank latches on next edge).
- REG_ADDR_O  output  3  bank address.
- REG_DAT_I  input  8  bank read data.
- REG_DAT_O  output  8  write data to bank.
- FLAG_C_O, FLAG_Z_O, FLAG_S_O, FLAG_P_O  output  1 each  carry/borrow, zero, sign, even parity.

Behaviour:
- Clock and reset:
  - One clock, CLK_I.
  - RST_I is synchronous, active-high.
  - Reset forces state IDLE and clears all four flags, the operand latches and the result register.
  - All REG_* outputs, BUSY_O and DONE_O are 0 in the cycle after the reset edge.
- Bank control outputs:
  - Moore-decoded from the state register.
  - Outside RDA/RDB/WB: REG_CS_O=REG_RD_O=REG_WR_O=0, REG_ADDR_O=0, REG_DAT_O=0.
- States:
  - IDLE: if CMD_VALID_I=1, latch op/src/immen/imm.
    - Op 12-15 -> DONE.
    - Otherwise -> RDA.
    - CMD_VALID_I is ignored in every other state; no queueing.
  - RDA: CS=RD=1, ADDR=ACC_ADDR; TmpA<=REG_DAT_I.
    - Rotates -> EXEC.
    - Op 0-7 with immen=1 -> EXEC, with TmpB<=imm.
    - Otherwise -> RDB.
  - RDB: CS=RD=1, ADDR=src; TmpB<=REG_DAT_I; -> EXEC.
    - src=ACC_ADDR is legal (e.g. ADD A gives 2A).
  - EXEC: compute; Result<=r; update flags.
    - CMP -> DONE.
    - All others -> WB.
  - WB: CS=WR=1, ADDR=ACC_ADDR, REG_DAT_O=Result; -> DONE.
  - DONE: DONE_O=1, BUSY_O=1; -> IDLE.
- Latency (accept edge in cycle 0, DONE_O high in cycle N):
  - Register arithmetic/logic: N=5.
  - Immediate arithmetic/logic and rotates: N=4.
  - CMP with register: N=4.
  - CMP with immediate: N=3.
  - NOP: N=1.
  - Next command accepted no earlier than cycle N+1.
- Arithmetic (9-bit internally; result is low 8 bits):
  - ADD: A+B, C=bit8.
  - ADC: A+B+C.
  - SUB/CMP: A-B, C=1 iff A<B unsigned.
  - SBB: A-B-C, C=1 iff A<B+C (borrow).
  - For ops 0-3 and 7, Z/S/P are set from the 8-bit result.
- Logic:
  - ANA, XRA and ORA give the bitwise result, clear C, and set Z/S/P from the result.
- Flag definitions: Z = result==0; S = result[7]; P = 1 when the result has even parity (XNOR reduce).
- Rotates (only C changes; Z/S/P hold):
  - RLC: {A[6:0],A[7]}, C=A[7].
  - RRC: {A[0],A[7:1]}, C=A[0].
  - RAL: {A[6:0],C}, C=A[7].
  - RAR: {C,A[7:1]}, C=A[0].
- NOP: no bank access, flags unchanged.
- Reset mid-operation:
  - Aborts the operation with no write.
  - If RST_I is high during WB, the bank still sees WR for that cycle. Bank reset is asserted with ours at top level, so the written value is discarded.

Test Plan:
- Reset, then ADD reg: A=0x3C, B(src 2)=0xC8 -> DONE_O in cycle 5; A=0x04, C=1, Z=0, S=0, P=0; one WR pulse, at ADDR 0 in cycle 4.
- SUB immediate: A=0x10, imm 0x20 -> A=0xF0, C=1, S=1, Z=0, P=1; DONE_O in cycle 4; no RDB cycle.
- CMP register: A=0x55, B=0x55 -> Z=1, C=0, P=1; A still 0x55; REG_WR_O never asserted; DONE_O in cycle 4.
- Rotate chain with prior C=1 and A=0x81: RAL -> A=0x03, C=1. Then RRC -> A=0x81, C=1. Then RAR -> A=0xC0, C=1. Z/S/P unchanged throughout.
- Handshake: CMD_VALID_I held high across two commands -> second accepted only in the IDLE cycle after DONE. NOP (op 14) -> DONE_O in cycle 1 with zero REG_CS_O activity.
- RST_I asserted in RDB of an ADD -> next cycle IDLE, BUSY_O=0, flags 0, no REG_WR_O pulse, A unchanged.
